// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and arbitrate three push-buttons into single-cycle press pulses
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       btn_start_raw,
  input  logic       btn_prog_raw,
  input  logic       btn_regr_raw,
  output logic       start,
  output logic       progressive,
  output logic       regressive,
  output logic       conflict,
  output logic [2:0] held
);
  typedef enum logic [1:0] {IDLE, CHK_PRESS, PRESSED, CHK_REL} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_cnt
    $error("DEBOUNCE_CYCLES does not fit CNT_W");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  logic [2:0] raw, p;
  assign raw = {btn_start_raw, btn_prog_raw, btn_regr_raw};
  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sy;
    logic [CNT_W-1:0] cnt;
    logic pr;
    logic s;
    state_t st;
    assign s = sy[SYNC_STAGES-1];
    assign p[g] = pr;
    assign held[g] = (st == PRESSED) || (st == CHK_REL);
    always_ff @(posedge clk_100MHz) begin
      if (reset) begin
        sy <= '0;
        cnt <= '0;
        pr <= 1'b0;
        st <= IDLE;
      end else begin
        sy <= {sy[SYNC_STAGES-2:0], raw[g]};
        pr <= 1'b0;
        cnt <= '0;
        case (st)
          IDLE: if (s) st <= CHK_PRESS;
          CHK_PRESS:
            if (!s) st <= IDLE;
            else if (cnt == LAST) begin
              st <= PRESSED;
              pr <= 1'b1;
            end else cnt <= cnt + 1'b1;
          PRESSED: if (!s) st <= CHK_REL;
          CHK_REL:
            if (s) st <= PRESSED;
            else if (cnt == LAST) st <= IDLE;
            else cnt <= cnt + 1'b1;
          default: st <= IDLE;
        endcase
      end
    end
  end
  // start always wins; a coincident direction request is dropped without flagging conflict
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      start <= 1'b0;
      progressive <= 1'b0;
      regressive <= 1'b0;
      conflict <= 1'b0;
    end else begin
      start <= p[2];
      progressive <= p[1] & ~p[0] & ~p[2];
      regressive <= p[0] & ~p[1] & ~p[2];
      conflict <= p[1] & p[0] & ~p[2];
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed test-plan cases plus random button activity against a run-length model
module tb_button_conditioner;
  localparam int D = 4;
  localparam int S = 2;
  logic clk_100MHz = 1'b0;
  logic reset = 1'b1;
  logic btn_start_raw = 1'b0, btn_prog_raw = 1'b0, btn_regr_raw = 1'b0;
  logic start, progressive, regressive, conflict;
  logic [2:0] held;
  always #5 clk_100MHz = ~clk_100MHz;
  button_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(20), .SYNC_STAGES(S)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset),
    .btn_start_raw(btn_start_raw), .btn_prog_raw(btn_prog_raw), .btn_regr_raw(btn_regr_raw),
    .start(start), .progressive(progressive), .regressive(regressive), .conflict(conflict),
    .held(held)
  );
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [2:0] sq [S];
  int run [3];
  logic [2:0] cur, lvl, acc_prev;
  int cyc, n_start, n_prog, n_regr, n_conf, start_at, prog_at, conf_at;
  int h_first [3], h_last [3];
  task automatic begin_test();
    cyc = 0;
    {n_start, n_prog, n_regr, n_conf} = '0;
    {start_at, prog_at, conf_at} = {-1, -1, -1};
    for (int c = 0; c < 3; c++) begin
      h_first[c] = -1;
      h_last[c] = -1;
    end
  endtask
  task automatic step(input logic rst, input logic [2:0] raw);
    logic [2:0] s_now, acc;
    logic [3:0] oe;
    reset = rst;
    {btn_start_raw, btn_prog_raw, btn_regr_raw} = raw;
    @(posedge clk_100MHz);
    oe = '0;
    if (rst) begin
      for (int i = 0; i < S; i++) sq[i] = '0;
      for (int c = 0; c < 3; c++) run[c] = 0;
      cur = '0;
      lvl = '0;
      acc_prev = '0;
    end else begin
      oe = {acc_prev[2], acc_prev[1] & ~acc_prev[0] & ~acc_prev[2],
            acc_prev[0] & ~acc_prev[1] & ~acc_prev[2], acc_prev[1] & acc_prev[0] & ~acc_prev[2]};
      s_now = sq[S-1];
      for (int i = S - 1; i > 0; i--) sq[i] = sq[i-1];
      sq[0] = raw;
      acc = '0;
      for (int c = 0; c < 3; c++) begin
        if (s_now[c] == cur[c]) run[c]++;
        else begin
          cur[c] = s_now[c];
          run[c] = 1;
        end
        if (s_now[c] != lvl[c] && run[c] >= D + 1) begin
          lvl[c] = s_now[c];
          acc[c] = s_now[c];
        end
      end
      acc_prev = acc;
    end
    #1;
    check("pulses", {28'd0, start, progressive, regressive, conflict}, {28'd0, oe});
    check("held", {29'd0, held}, {29'd0, lvl});
    if (start) begin n_start++; if (start_at < 0) start_at = cyc; end
    if (progressive) begin n_prog++; if (prog_at < 0) prog_at = cyc; end
    if (regressive) n_regr++;
    if (conflict) begin n_conf++; if (conf_at < 0) conf_at = cyc; end
    for (int c = 0; c < 3; c++) if (held[c]) begin
      if (h_first[c] < 0) h_first[c] = cyc;
      h_last[c] = cyc;
    end
    cyc++;
  endtask
  task automatic hold(input int n, input logic [2:0] raw);
    for (int i = 0; i < n; i++) step(1'b0, raw);
  endtask
  initial begin
    logic [2:0] lv;
    int left [3];
    repeat (3) step(1'b1, 3'b000);
    hold(4, 3'b000);
    begin_test();
    hold(20, 3'b100);
    hold(12, 3'b000);
    check("clean_lat", start_at, 7);
    check("clean_count", n_start, 1);
    check("clean_held_rise", h_first[2], 6);
    check("clean_held_fall", h_last[2], 25);
    begin_test();
    step(1'b0, 3'b010); step(1'b0, 3'b000); step(1'b0, 3'b010); step(1'b0, 3'b000);
    hold(10, 3'b000);
    check("bounce_none", n_prog, 0);
    check("bounce_held", h_first[1], -1);
    begin_test();
    step(1'b0, 3'b010); step(1'b0, 3'b000); step(1'b0, 3'b010); step(1'b0, 3'b000);
    hold(15, 3'b010);
    hold(12, 3'b000);
    check("bounce_lat", prog_at, 11);
    check("bounce_count", n_prog, 1);
    begin_test();
    hold(10, 3'b010);
    hold(2, 3'b000);
    step(1'b0, 3'b010);
    hold(12, 3'b000);
    check("relbounce_count", n_prog, 1);
    check("relbounce_fall", h_last[1], 18);
    begin_test();
    hold(10, 3'b011);
    hold(12, 3'b000);
    check("conflict_count", n_conf, 1);
    check("conflict_lat", conf_at, 7);
    check("conflict_dirs", n_prog + n_regr, 0);
    begin_test();
    hold(10, 3'b101);
    hold(12, 3'b000);
    check("prio_start", n_start, 1);
    check("prio_regr", n_regr, 0);
    check("prio_conf", n_conf, 0);
    begin_test();
    hold(3, 3'b100);
    step(1'b1, 3'b100); step(1'b1, 3'b100);
    hold(15, 3'b100);
    hold(12, 3'b000);
    check("rst_mid_lat", start_at, 12);
    check("rst_mid_count", n_start, 1);
    lv = '0;
    for (int c = 0; c < 3; c++) left[c] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < 3; c++) begin
        if (left[c] == 0) begin
          lv[c] = 1'($urandom_range(0, 1));
          left[c] = $urandom_range(1, 14);
        end
        left[c]--;
      end
      step($urandom_range(0, 299) == 0, lv);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
